// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU/memory-side bus bundle for the OAM sprite DMA sequencer
interface oam_dma_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_dout;
    logic                  cpu_r_w_n;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  rdy;
    logic                  bus_grant;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_dout;
    logic                  dma_r_w_n;
    logic                  dma_busy;

    modport master (
        input  cpu_addr, cpu_dout, cpu_r_w_n, mem_din,
        output rdy, bus_grant, dma_addr, dma_dout, dma_r_w_n, dma_busy
    );

    modport slave (
        output cpu_addr, cpu_dout, cpu_r_w_n, mem_din,
        input  rdy, bus_grant, dma_addr, dma_dout, dma_r_w_n, dma_busy
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA sequencer / 6502 bus arbiter (DMA_ALIGN_EN adds the odd-cycle ALIGN state)
module oam_dma_ctrl #(
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] OAM_PORT_ADDR = 16'h2004,
    parameter int                    XFER_LEN      = 256
) (
    input  logic     clk,
    input  logic     reset_n,
    oam_dma_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
`ifdef DMA_ALIGN_EN
        S_ALIGN = 3'd2,
`endif
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [8:0]            idx_q, idx_d;
    logic [7:0]            page_q, page_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rdy_q, rdy_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  r_w_n_q, r_w_n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  trigger;
    logic                  last_byte;

    assign trigger   = !bus.cpu_r_w_n && (bus.cpu_addr == TRIGGER_ADDR);
    assign last_byte = (idx_q == 9'(XFER_LEN - 1));

`ifdef DMA_ALIGN_EN
    logic parity_q, parity_d;
    assign parity_d = ~parity_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_q <= 1'b0;
        else          parity_q <= parity_d;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // The 6502 only honours rdy on read cycles, so HALT waits out any write burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trigger) state_d = S_HALT;
            S_HALT:  if (bus.cpu_r_w_n) begin
`ifdef DMA_ALIGN_EN
                         state_d = parity_q ? S_ALIGN : S_READ;
`else
                         state_d = S_READ;
`endif
                     end
`ifdef DMA_ALIGN_EN
            S_ALIGN: state_d = S_READ;
`endif
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = last_byte ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        idx_d  = idx_q;
        page_d = page_q;
        data_d = data_q;
        if (state_q == S_IDLE && trigger) page_d = bus.cpu_dout[7:0];
        if (state_q == S_READ)            data_d = bus.mem_din;
        if (state_q == S_WRITE)           idx_d  = last_byte ? 9'd0 : idx_q + 9'd1;

        rdy_d   = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        grant_d = (state_d == S_READ) || (state_d == S_WRITE);
        r_w_n_d = (state_d != S_WRITE);
        addr_d  = '0;
        if (state_d == S_READ)       addr_d = ADDR_WIDTH'({page_d, idx_d[7:0]});
        else if (state_d == S_WRITE) addr_d = OAM_PORT_ADDR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            page_q  <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b1;
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
            r_w_n_q <= 1'b1;
            addr_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            page_q  <= page_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            r_w_n_q <= r_w_n_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.bus_grant = grant_q;
    assign bus.dma_busy  = busy_q;
    assign bus.dma_r_w_n = r_w_n_q;
    assign bus.dma_addr  = addr_q;
    assign bus.dma_dout  = data_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - self-checking bench for oam_dma_ctrl (256-byte and 4-byte instances)
module tb_oam_dma_ctrl;
    localparam int LEN0 = 256;
    localparam int LEN1 = 4;
`ifdef DMA_ALIGN_EN
    localparam int ALIGN_ON = 1;
`else
    localparam int ALIGN_ON = 0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] memf(input logic [15:0] a);
        logic [7:0] pg;
        pg = a[15:8] - 8'h02;
        return (a[7:0] ^ 8'h5A) + pg * 8'd37;
    endfunction

    oam_dma_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b0 ();
    oam_dma_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b1 ();

    oam_dma_ctrl #(.XFER_LEN(LEN0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    oam_dma_ctrl #(.XFER_LEN(LEN1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));

    logic [1:0][15:0] cpu_addr;
    logic [1:0][7:0]  cpu_dout;
    logic [1:0]       cpu_rw;
    logic [1:0]       rdy, grant, rw, busy;
    logic [1:0][15:0] addr;
    logic [1:0][7:0]  dout;

    assign b0.cpu_addr  = cpu_addr[0];
    assign b0.cpu_dout  = cpu_dout[0];
    assign b0.cpu_r_w_n = cpu_rw[0];
    assign b0.mem_din   = memf(b0.dma_addr);
    assign b1.cpu_addr  = cpu_addr[1];
    assign b1.cpu_dout  = cpu_dout[1];
    assign b1.cpu_r_w_n = cpu_rw[1];
    assign b1.mem_din   = memf(b1.dma_addr);

    assign rdy   = {b1.rdy, b0.rdy};
    assign grant = {b1.bus_grant, b0.bus_grant};
    assign rw    = {b1.dma_r_w_n, b0.dma_r_w_n};
    assign busy  = {b1.dma_busy, b0.dma_busy};
    assign addr  = {b1.dma_addr, b0.dma_addr};
    assign dout  = {b1.dma_dout, b0.dma_dout};

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, want %0h", name, inst, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Transaction-level model: a transfer is a trigger edge, a halt window that ends on
    // the first CPU read (plus an optional align cycle), 2*LEN bus cycles, then one DONE cycle.
    int         edge_n      = 0;
    int         m_par       = 0;
    int         len [2]     = '{LEN0, LEN1};
    bit         m_busy [2]  = '{1'b0, 1'b0};
    int         m_trig [2]  = '{0, 0};
    int         m_start [2] = '{-1, -1};
    logic [7:0] m_page [2]  = '{8'h00, 8'h00};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_n = 0;
            for (int i = 0; i < 2; i++) begin
                m_busy[i]  = 1'b0;
                m_start[i] = -1;
            end
        end else begin
            m_par = edge_n % 2;
            edge_n++;
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    if (m_start[i] < 0) begin
                        if (cpu_rw[i] && edge_n > m_trig[i])
                            m_start[i] = edge_n + ((ALIGN_ON == 1 && m_par == 1) ? 1 : 0);
                    end else if (edge_n > m_start[i] + 2 * len[i]) begin
                        m_busy[i] = 1'b0;
                    end
                end else if (!cpu_rw[i] && cpu_addr[i] == 16'h4014) begin
                    m_busy[i]  = 1'b1;
                    m_trig[i]  = edge_n;
                    m_start[i] = -1;
                    m_page[i]  = cpu_dout[i];
                end
            end
        end
    end

    logic        e_rdy, e_grant, e_rw;
    logic [15:0] e_addr, e_src;
    logic [7:0]  e_dout;
    bit          e_chk_addr, e_chk_dout;
    int          k;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_rdy = 1'b1; e_grant = 1'b0; e_rw = 1'b1;
            e_addr = 16'h0; e_dout = 8'h0; e_src = 16'h0;
            e_chk_addr = 1'b0; e_chk_dout = 1'b0;
            if (m_busy[i]) begin
                e_rdy = 1'b0;
                if (m_start[i] >= 0 && edge_n >= m_start[i]) begin
                    k = edge_n - m_start[i];
                    if (k < 2 * len[i]) begin
                        e_grant    = 1'b1;
                        e_chk_addr = 1'b1;
                        e_src      = {m_page[i], 8'(k / 2)};
                        if (k % 2 == 0) begin
                            e_addr = e_src;
                        end else begin
                            e_addr     = 16'h2004;
                            e_rw       = 1'b0;
                            e_dout     = memf(e_src);
                            e_chk_dout = 1'b1;
                        end
                    end
                end
            end
            chk("rdy", i, 32'(rdy[i]), 32'(e_rdy));
            chk("bus_grant", i, 32'(grant[i]), 32'(e_grant));
            chk("dma_r_w_n", i, 32'(rw[i]), 32'(e_rw));
            chk("dma_busy", i, 32'(busy[i]), 32'(m_busy[i]));
            if (e_chk_addr) chk("dma_addr", i, 32'(addr[i]), 32'(e_addr));
            if (e_chk_dout) chk("dma_dout", i, 32'(dout[i]), 32'(e_dout));
        end
    end

    logic [7:0]  wq0[$];
    logic [15:0] rq0[$];
    logic [15:0] rq1[$];
    int          zero_hit = 0;
    int          run_cnt [2] = '{0, 0};
    int          last_span [2] = '{0, 0};

    always @(negedge clk) begin
        if (grant[0] && rw[0])                        rq0.push_back(addr[0]);
        if (grant[0] && !rw[0] && addr[0] == 16'h2004) wq0.push_back(dout[0]);
        if (grant[1] && rw[1])                        rq1.push_back(addr[1]);
        if (grant[1] && addr[1] == 16'h0000)          zero_hit++;
        for (int i = 0; i < 2; i++) begin
            if (!rdy[i]) run_cnt[i]++;
            else if (run_cnt[i] != 0) begin
                last_span[i] = run_cnt[i];
                run_cnt[i]   = 0;
            end
        end
    end

    task automatic clear_logs();
        wq0.delete();
        rq0.delete();
        rq1.delete();
        zero_hit = 0;
    endtask

    task automatic set_idle(input int i);
        cpu_rw[i]   = 1'b1;
        cpu_addr[i] = 16'h8000;
        cpu_dout[i] = 8'h00;
    endtask

    task automatic run_xfer(input int i, input logic [7:0] pg, input int nwr, input bit mid);
        int guard;
        cpu_rw[i] = 1'b0; cpu_addr[i] = 16'h4014; cpu_dout[i] = pg;
        @(negedge clk);
        for (int w = 0; w < nwr; w++) begin
            cpu_rw[i] = 1'b0; cpu_addr[i] = 16'h0100; cpu_dout[i] = 8'h33;
            @(negedge clk);
        end
        set_idle(i);
        guard = 0;
        while (rdy[i] == 1'b0 && guard < 2000) begin
            if (mid && guard == 100) begin
                cpu_rw[i] = 1'b0; cpu_addr[i] = 16'h4014; cpu_dout[i] = 8'h07;
            end else begin
                set_idle(i);
            end
            @(negedge clk);
            guard++;
        end
        set_idle(i);
        chk("xfer_completes", i, 32'(rdy[i]), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int guard;
        set_idle(0);
        set_idle(1);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        cpu_rw[0] = 1'b0; cpu_addr[0] = 16'h4014; cpu_dout[0] = 8'h02;
        #1;
        chk("rst_rdy", 0, 32'(rdy[0]), 32'd1);
        chk("rst_grant", 0, 32'(grant[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("rst_rw", 0, 32'(rw[0]), 32'd1);
        chk("rst_addr", 0, 32'(addr[0]), 32'h0);
        chk("rst_dout", 0, 32'(dout[0]), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        set_idle(0);
        repeat (3) @(negedge clk);
        chk("no_trigger_in_reset", 0, 32'(busy[0]), 32'd0);

        // 256-byte copy from page 0x02
        clear_logs();
        run_xfer(0, 8'h02, 0, 1'b0);
        chk_range("t1_span", last_span[0], 514, 514 + ALIGN_ON);
        chk("t1_nwrites", 0, 32'(wq0.size()), 32'd256);
        chk("t1_w0", 0, 32'(wq0[0]), 32'h5A);
        chk("t1_w40", 0, 32'(wq0[64]), 32'h1A);
        chk("t1_wff", 0, 32'(wq0[255]), 32'hA5);
        chk("t1_r0", 0, 32'(rq0[0]), 32'h0200);
        chk("t1_rff", 0, 32'(rq0[255]), 32'h02FF);

        // CPU still writing for two cycles after the trigger
        clear_logs();
        run_xfer(0, 8'h02, 2, 1'b0);
        chk_range("t3_span", last_span[0], 516, 516 + ALIGN_ON);
        chk("t3_r0", 0, 32'(rq0[0]), 32'h0200);

        // re-trigger with page 0x07 in the middle of a transfer
        clear_logs();
        run_xfer(0, 8'h02, 0, 1'b1);
        chk("t4_nwrites", 0, 32'(wq0.size()), 32'd256);
        chk("t4_w100", 0, 32'(wq0[100]), 32'h3E);
        chk("t4_rff", 0, 32'(rq0[255]), 32'h02FF);
        chk_range("t4_span", last_span[0], 514, 514 + ALIGN_ON);

        // 4-byte instance on the top page
        clear_logs();
        run_xfer(1, 8'hFF, 0, 1'b0);
        chk_range("t6_span", last_span[1], 10, 10 + ALIGN_ON);
        chk("t6_nreads", 1, 32'(rq1.size()), 32'd4);
        chk("t6_r0", 1, 32'(rq1[0]), 32'hFF00);
        chk("t6_r3", 1, 32'(rq1[3]), 32'hFF03);
        chk("t6_no_zero", 1, 32'(zero_hit), 32'd0);

        // reset during the WRITE of idx 0x40, then restart
        clear_logs();
        cpu_rw[0] = 1'b0; cpu_addr[0] = 16'h4014; cpu_dout[0] = 8'h02;
        @(negedge clk);
        set_idle(0);
        guard = 0;
        while (!(m_start[0] >= 0 && edge_n - m_start[0] == 129) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_reached_idx40", 0, 32'(guard < 1000), 32'd1);
        chk("t5_in_write", 0, 32'(rw[0]), 32'd0);
        chk("t5_write_addr", 0, 32'(addr[0]), 32'h2004);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_rdy", 0, 32'(rdy[0]), 32'd1);
        chk("t5_grant", 0, 32'(grant[0]), 32'd0);
        chk("t5_rw", 0, 32'(rw[0]), 32'd1);
        chk("t5_busy", 0, 32'(busy[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        run_xfer(0, 8'h02, 0, 1'b0);
        chk("t5_restart_r0", 0, 32'(rq0[0]), 32'h0200);
        chk("t5_restart_w0", 0, 32'(wq0[0]), 32'h5A);
        chk("t5_restart_n", 0, 32'(wq0.size()), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
